// File: rtl/cpu_mem_pkg.sv
// Shared MEM-stage definitions for the SRAM-interface CPU.
// Holds the load/store type encodings, the load FSM state encoding and the
// load alignment check used by the load unit.
package cpu_mem_pkg;

  // Data SRAM read latency; the load unit is built for exactly one cycle.
  localparam int unsigned SRAM_LAT = 1;

  // Load type encodings (ld_type).
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LW  = 3'b111;

  // Store type encodings, kept here so both paths decode from one place.
  localparam logic [2:0] ST_SB = 3'b101;
  localparam logic [2:0] ST_SH = 3'b110;
  localparam logic [2:0] ST_SW = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } ld_state_e;

  // Halfword loads need addr[0]==0, word loads need addr[1:0]==0.
  function automatic logic ld_misaligned(input logic [2:0] ld_type, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (ld_type)
      LD_LH, LD_LHU: mis = off[0];
      LD_LW:         mis = |off;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_data_extract.sv
// Combinational load data extraction.
// Selects the addressed byte/half/word out of a 32-bit SRAM read word and
// sign- or zero-extends it to 32 bits.
//   rdata_i   : raw word read from the data SRAM
//   ld_type_i : load type encoding (LD_*)
//   off_i     : byte offset within the word (addr[1:0])
//   data_o    : extended load result
module load_data_extract
  import cpu_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
  end

  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (ld_type_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'd0, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit.
// Accepts a load request, issues a word-aligned SRAM read, captures the
// one-cycle-latency read data, extends it and hands the result (or an
// address-error exception) to WB over a valid/ready handshake.
//   clk, resetn           : clock, synchronous active-low reset
//   flush                 : kills any in-flight load
//   ld_valid/ld_ready     : load request handshake; ld_type/ld_addr/ld_dest
//   data_sram_*           : read-only data SRAM port
//   wb_valid/wb_ready     : result handshake; wb_data/wb_dest/wb_adel/wb_badvaddr
module mem_load_unit
  import cpu_mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_addr,
  input  logic [4:0]  ld_dest,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_adel,
  output logic [31:0] wb_badvaddr
);

  ld_state_e   state_q;
  logic [31:0] result_q;
  logic [4:0]  dest_q;
  logic [31:0] badvaddr_q;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic        adel_q;

  logic        accept;
  logic        misaligned;
  logic [31:0] ext_data;

  // A new request can enter in IDLE, or in RESP when WB drains the result
  // in the same cycle.
  assign ld_ready = resetn && !flush &&
                    (state_q == StIdle || (state_q == StResp && wb_ready));
  assign accept     = ld_valid && ld_ready;
  assign misaligned = ld_misaligned(ld_type, ld_addr[1:0]);

  assign data_sram_en   = accept && !misaligned;
  assign data_sram_wen  = 4'b0000;
  assign data_sram_addr = {ld_addr[31:2], 2'b00};

  assign wb_valid    = (state_q == StResp) && !flush;
  assign wb_data     = result_q;
  assign wb_dest     = dest_q;
  assign wb_adel     = adel_q;
  assign wb_badvaddr = badvaddr_q;

  load_data_extract u_extract (
    .rdata_i   (data_sram_rdata),
    .ld_type_i (type_q),
    .off_i     (off_q),
    .data_o    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      result_q   <= 32'd0;
      dest_q     <= 5'd0;
      badvaddr_q <= 32'd0;
      type_q     <= 3'd0;
      off_q      <= 2'd0;
      adel_q     <= 1'b0;
    end else if (flush) begin
      // Any pending SRAM response or undelivered result is dropped.
      state_q <= StIdle;
    end else if (accept) begin
      dest_q     <= ld_dest;
      badvaddr_q <= ld_addr;
      if (misaligned) begin
        adel_q   <= 1'b1;
        result_q <= 32'd0;
        state_q  <= StResp;
      end else begin
        type_q  <= ld_type;
        off_q   <= ld_addr[1:0];
        state_q <= StWait;
      end
    end else begin
      case (state_q)
        StWait: begin
          result_q <= ext_data;
          adel_q   <= 1'b0;
          state_q  <= StResp;
        end
        StResp: begin
          if (wb_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_type;
  logic [31:0] ld_addr;
  logic [4:0]  ld_dest;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_adel;
  logic [31:0] wb_badvaddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_load_unit dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_type         (ld_type),
    .ld_addr         (ld_addr),
    .ld_dest         (ld_dest),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_rdata (data_sram_rdata),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_data         (wb_data),
    .wb_dest         (wb_dest),
    .wb_adel         (wb_adel),
    .wb_badvaddr     (wb_badvaddr)
  );

  typedef struct {
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] rd;
    logic [31:0] exp;
    logic        adel;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{LD_LB,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{LD_LBU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, 1'b0};
    vecs[2]  = '{LD_LB,  32'h0000_1001, 32'h80FF_1234, 32'h0000_0012, 1'b0};
    vecs[3]  = '{LD_LBU, 32'h0000_1002, 32'h80FF_1234, 32'h0000_00FF, 1'b0};
    vecs[4]  = '{LD_LB,  32'h0000_1002, 32'h80FF_1234, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{LD_LHU, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_8001, 1'b0};
    vecs[6]  = '{LD_LH,  32'h0000_2002, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0};
    vecs[7]  = '{LD_LH,  32'h0000_2000, 32'h8001_7FFF, 32'h0000_7FFF, 1'b0};
    vecs[8]  = '{LD_LW,  32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{LD_LW,  32'h0000_3006, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[10] = '{LD_LH,  32'h0000_2001, 32'h2222_2222, 32'h0000_0000, 1'b1};
    vecs[11] = '{LD_LB,  32'h0000_1000, 32'h0000_00A5, 32'hFFFF_FFA5, 1'b0};
    vecs[12] = '{LD_LW,  32'h0000_3002, 32'h3333_3333, 32'h0000_0000, 1'b1};
    vecs[13] = '{LD_LHU, 32'h0000_2003, 32'h4444_4444, 32'h0000_0000, 1'b1};

    resetn = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_type = 3'd0;
    ld_addr = 32'd0; ld_dest = 5'd0; data_sram_rdata = 32'd0; wb_ready = 1'b0;
    tick();
    tick();
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_en", 32'(data_sram_en), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_adel", 32'(wb_adel), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_badvaddr", wb_badvaddr, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rst_release_ld_ready", 32'(ld_ready), 32'd1);

    // Table-driven single loads.
    for (int i = 0; i < 14; i++) begin
      ld_valid = 1'b1; ld_type = vecs[i].t; ld_addr = vecs[i].a;
      ld_dest = 5'(i + 1); wb_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'd1);
      chk($sformatf("v%0d_en", i), 32'(data_sram_en), 32'(!vecs[i].adel));
      chk($sformatf("v%0d_wen", i), 32'(data_sram_wen), 32'd0);
      if (!vecs[i].adel)
        chk($sformatf("v%0d_sram_addr", i), data_sram_addr, {vecs[i].a[31:2], 2'b00});
      tick();
      ld_valid = 1'b0;
      if (!vecs[i].adel) begin
        data_sram_rdata = vecs[i].rd;
        #1;
        chk($sformatf("v%0d_wait_wb_valid", i), 32'(wb_valid), 32'd0);
        chk($sformatf("v%0d_wait_ld_ready", i), 32'(ld_ready), 32'd0);
        tick();
        data_sram_rdata = 32'hBAD0_BAD0;
      end
      #1;
      chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp);
      chk($sformatf("v%0d_wb_adel", i), 32'(wb_adel), 32'(vecs[i].adel));
      chk($sformatf("v%0d_wb_dest", i), 32'(wb_dest), 32'(i + 1));
      if (vecs[i].adel)
        chk($sformatf("v%0d_badvaddr", i), wb_badvaddr, vecs[i].a);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_idle_wb_valid", i), 32'(wb_valid), 32'd0);
      chk($sformatf("v%0d_idle_ld_ready", i), 32'(ld_ready), 32'd1);
    end

    // Backpressure: result held stable, then a new load accepted on drain.
    ld_valid = 1'b1; ld_type = LD_LW; ld_addr = 32'h0000_4000; ld_dest = 5'd9;
    tick();
    ld_valid = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    tick();
    data_sram_rdata = 32'hBAD0_BAD0;
    ld_valid = 1'b1; ld_type = LD_LB; ld_addr = 32'h0000_5001; ld_dest = 5'd10;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_wb_valid", c), 32'(wb_valid), 32'd1);
      chk($sformatf("bp%0d_wb_data", c), wb_data, 32'hDEAD_BEEF);
      chk($sformatf("bp%0d_wb_dest", c), 32'(wb_dest), 32'd9);
      chk($sformatf("bp%0d_wb_adel", c), 32'(wb_adel), 32'd0);
      chk($sformatf("bp%0d_ld_ready", c), 32'(ld_ready), 32'd0);
      chk($sformatf("bp%0d_en", c), 32'(data_sram_en), 32'd0);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_drain_wb_valid", 32'(wb_valid), 32'd1);
    chk("bp_drain_ld_ready", 32'(ld_ready), 32'd1);
    chk("bp_drain_en", 32'(data_sram_en), 32'd1);
    chk("bp_drain_addr", data_sram_addr, 32'h0000_5000);
    tick();
    ld_valid = 1'b0; wb_ready = 1'b0; data_sram_rdata = 32'h0000_7F00;
    #1;
    chk("b2b_wait_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    data_sram_rdata = 32'hBAD0_BAD0;
    #1;
    chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b_wb_data", wb_data, 32'h0000_007F);
    chk("b2b_wb_dest", 32'(wb_dest), 32'd10);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // Flush in WAIT discards the read data.
    ld_valid = 1'b1; ld_type = LD_LW; ld_addr = 32'h0000_6000; ld_dest = 5'd11;
    tick();
    ld_valid = 1'b0; flush = 1'b1; data_sram_rdata = 32'h1234_5678;
    #1;
    chk("fw_wb_valid", 32'(wb_valid), 32'd0);
    chk("fw_ld_ready", 32'(ld_ready), 32'd0);
    chk("fw_en", 32'(data_sram_en), 32'd0);
    tick();
    flush = 1'b0; data_sram_rdata = 32'hBAD0_BAD0;
    #1;
    chk("fw_next_wb_valid", 32'(wb_valid), 32'd0);
    chk("fw_next_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    chk("fw_later_wb_valid", 32'(wb_valid), 32'd0);

    // Flush with a request in IDLE blocks acceptance.
    flush = 1'b1; ld_valid = 1'b1; ld_type = LD_LB; ld_addr = 32'h0000_6000;
    #1;
    chk("fi_ld_ready", 32'(ld_ready), 32'd0);
    chk("fi_en", 32'(data_sram_en), 32'd0);
    tick();
    flush = 1'b0; ld_valid = 1'b0;
    #1;
    chk("fi_next_wb_valid", 32'(wb_valid), 32'd0);
    chk("fi_next_ld_ready", 32'(ld_ready), 32'd1);

    // Flush in RESP suppresses delivery even with wb_ready high.
    ld_valid = 1'b1; ld_type = LD_LW; ld_addr = 32'h0000_6002; ld_dest = 5'd12;
    #1;
    chk("fr_en", 32'(data_sram_en), 32'd0);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("fr_wb_valid_t1", 32'(wb_valid), 32'd1);
    flush = 1'b1; wb_ready = 1'b1;
    #1;
    chk("fr_flush_wb_valid", 32'(wb_valid), 32'd0);
    chk("fr_flush_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    flush = 1'b0; wb_ready = 1'b0;
    #1;
    chk("fr_next_wb_valid", 32'(wb_valid), 32'd0);
    chk("fr_next_ld_ready", 32'(ld_ready), 32'd1);

    // Reset during RESP.
    ld_valid = 1'b1; ld_type = LD_LH; ld_addr = 32'h0000_7001; ld_dest = 5'd13;
    tick();
    ld_valid = 1'b0;
    #1;
    chk("rr_wb_valid", 32'(wb_valid), 32'd1);
    chk("rr_wb_adel", 32'(wb_adel), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rr_low_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    chk("rr_after_wb_valid", 32'(wb_valid), 32'd0);
    chk("rr_after_wb_adel", 32'(wb_adel), 32'd0);
    chk("rr_after_wb_data", wb_data, 32'd0);
    chk("rr_after_ld_ready", 32'(ld_ready), 32'd0);
    resetn = 1'b1;
    #1;
    chk("rr_release_ld_ready", 32'(ld_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
